// File: rtl/dc_filter_if.sv
// Valid/busy streaming channel carrying one 24-bit RGB pixel ([7:0]=R, [15:8]=G, [23:16]=B).
// A transfer happens on a rising edge where vld=1 and busy=0.
interface dc_filter_if;
  logic        vld;
  logic [23:0] data;
  logic        busy;

  modport master (output vld, output data, input busy);
  modport slave  (input vld, input data, output busy);
endinterface

// File: rtl/dc_filter.sv
// Streaming 3x3 mean filter: every nine consecutive accepted pixels produce one pixel holding
// the per-channel truncated mean. Input stage and averaging stage are joined by an external loopback.
module dc_filter (
  input  logic        i_clk,
  input  logic        i_rst,
  dc_filter_if.slave  i_rgb,
  dc_filter_if.master o_rgb_inside,
  dc_filter_if.slave  i_rgb_inside,
  dc_filter_if.master o_result
);

  // Exact floor(x/9) for x <= 2295: 3641/32768 overshoots 1/9 by 1/294912, harmless below 32768.
  function automatic logic [7:0] div9(input logic [11:0] x);
    return 8'((24'(x) * 24'd3641) >> 15);
  endfunction

  logic        r_a_valid, w_a_valid;
  logic [23:0] r_a_data,  w_a_data;
  logic [3:0]  r_cnt,     w_cnt;
  logic [11:0] r_sum_r,   w_sum_r;
  logic [11:0] r_sum_g,   w_sum_g;
  logic [11:0] r_sum_b,   w_sum_b;
  logic        r_r_valid, w_r_valid;
  logic [23:0] r_r_data,  w_r_data;

  logic        w_in_xfer, w_a_out_xfer, w_mid_xfer, w_res_xfer;
  logic [11:0] w_add_r, w_add_g, w_add_b;

  // Busy depends only on registered valid bits and downstream busy, never on an incoming vld.
  assign i_rgb.busy        = r_a_valid & o_rgb_inside.busy;
  assign i_rgb_inside.busy = r_r_valid & o_result.busy;

  assign o_rgb_inside.vld  = r_a_valid;
  assign o_rgb_inside.data = r_a_data;
  assign o_result.vld      = r_r_valid;
  assign o_result.data     = r_r_data;

  assign w_in_xfer    = i_rgb.vld & ~i_rgb.busy;
  assign w_a_out_xfer = r_a_valid & ~o_rgb_inside.busy;
  assign w_mid_xfer   = i_rgb_inside.vld & ~i_rgb_inside.busy;
  assign w_res_xfer   = r_r_valid & ~o_result.busy;

  assign w_add_r = r_sum_r + 12'(i_rgb_inside.data[7:0]);
  assign w_add_g = r_sum_g + 12'(i_rgb_inside.data[15:8]);
  assign w_add_b = r_sum_b + 12'(i_rgb_inside.data[23:16]);

  always_comb begin
    w_a_valid = r_a_valid;
    w_a_data  = r_a_data;
    w_cnt     = r_cnt;
    w_sum_r   = r_sum_r;
    w_sum_g   = r_sum_g;
    w_sum_b   = r_sum_b;
    w_r_valid = r_r_valid;
    w_r_data  = r_r_data;

    if (w_in_xfer) begin
      w_a_valid = 1'b1;
      w_a_data  = i_rgb.data;
    end else if (w_a_out_xfer) begin
      w_a_valid = 1'b0;
    end

    if (w_res_xfer) begin
      w_r_valid = 1'b0;
    end

    // A new result on the same edge as an outgoing one keeps r_valid set.
    if (w_mid_xfer) begin
      if (r_cnt == 4'd8) begin
        w_r_valid = 1'b1;
        w_r_data  = {div9(w_add_b), div9(w_add_g), div9(w_add_r)};
        w_sum_r   = '0;
        w_sum_g   = '0;
        w_sum_b   = '0;
        w_cnt     = '0;
      end else begin
        w_sum_r   = w_add_r;
        w_sum_g   = w_add_g;
        w_sum_b   = w_add_b;
        w_cnt     = r_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a_valid <= 1'b0;
      r_a_data  <= '0;
      r_cnt     <= '0;
      r_sum_r   <= '0;
      r_sum_g   <= '0;
      r_sum_b   <= '0;
      r_r_valid <= 1'b0;
      r_r_data  <= '0;
    end else begin
      r_a_valid <= w_a_valid;
      r_a_data  <= w_a_data;
      r_cnt     <= w_cnt;
      r_sum_r   <= w_sum_r;
      r_sum_g   <= w_sum_g;
      r_sum_b   <= w_sum_b;
      r_r_valid <= w_r_valid;
      r_r_data  <= w_r_data;
    end
  end

endmodule

// File: tb/tb_dc_filter.sv
// Bench for dc_filter: table of directed windows with hand-computed means, plus sequences
// for reset, result backpressure and random loopback stalls.
module tb_dc_filter;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  dc_filter_if u_in ();
  dc_filter_if u_ins ();
  dc_filter_if u_mid ();
  dc_filter_if u_res ();

  logic r_stall = 1'b0;

  // Loopback with an injectable stall between o_rgb_inside and i_rgb_inside.
  assign u_mid.vld  = u_ins.vld & ~r_stall;
  assign u_mid.data = u_ins.data;
  assign u_ins.busy = u_mid.busy | r_stall;

  dc_filter u_dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_rgb        (u_in),
    .o_rgb_inside (u_ins),
    .i_rgb_inside (u_mid),
    .o_result     (u_res)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int last_acc_edge = 0;

  logic [23:0] got_q[$];
  int          got_edge[$];

  always @(posedge i_clk) cyc <= cyc + 1;

  // Inputs only change #1 after a rising edge, so the negedge view predicts the next edge.
  always @(negedge i_clk) begin
    if (!i_rst && u_res.vld && !u_res.busy) begin
      got_q.push_back(u_res.data);
      got_edge.push_back(cyc + 1);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic send_pixel(input logic [23:0] d);
    int waited = 0;
    u_in.vld  = 1'b1;
    u_in.data = d;
    forever begin
      @(negedge i_clk);
      if (!u_in.busy) begin
        @(posedge i_clk);
        #1;
        last_acc_edge = cyc;
        break;
      end
      step(1);
      waited++;
      if (waited > 300) begin
        check("send_timeout", 32'(waited), 32'd0);
        break;
      end
    end
  endtask

  task automatic idle_in();
    u_in.vld = 1'b0;
  endtask

  task automatic wait_results(input int n, input int budget);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      step(1);
      k++;
    end
    step(3);
  endtask

  typedef struct {
    string            name;
    logic [8:0][23:0] pix;
    logic [23:0]      exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int t9;
    logic [23:0] rpix[27];
    int sr, sg, sb;

    vecs[0].name = "flat_302010"; vecs[0].pix = {9{24'h302010}}; vecs[0].exp = 24'h302010;
    vecs[1].name = "all_ff";      vecs[1].pix = {9{24'hFFFFFF}}; vecs[1].exp = 24'hFFFFFF;
    vecs[2].name = "all_zero";    vecs[2].pix = {9{24'h000000}}; vecs[2].exp = 24'h000000;
    vecs[3].name = "r_ramp";      vecs[3].exp = 24'h000004;
    for (int i = 0; i < 9; i++) vecs[3].pix[i] = 24'(i);
    vecs[4].name = "trunc";       vecs[4].pix = {24'h080808, {8{24'h000000}}};
    vecs[4].exp = 24'h000000;
    // B: 9*100=900 -> 100; G: 8*10+17=97 -> 10; R: 254*8+255=2287 -> 254
    vecs[5].name = "mixed";       vecs[5].pix = {24'h6411FF, {8{24'h640AFE}}};
    vecs[5].exp = 24'h640AFE;

    u_in.vld   = 1'b0;
    u_in.data  = '0;
    u_res.busy = 1'b1;
    r_stall    = 1'b1;
    step(3);
    i_rst = 1'b0;
    #1;
    check("rst_inside_vld", 32'(u_ins.vld), 32'd0);
    check("rst_result_vld", 32'(u_res.vld), 32'd0);
    check("rst_in_busy", 32'(u_in.busy), 32'd0);
    check("rst_mid_busy", 32'(u_mid.busy), 32'd0);
    check("rst_inside_data", 32'(u_ins.data), 32'd0);
    check("rst_result_data", 32'(u_res.data), 32'd0);
    u_res.busy = 1'b0;
    r_stall    = 1'b0;
    step(1);

    for (int v = 0; v < 6; v++) begin
      got_q.delete();
      got_edge.delete();
      for (int i = 0; i < 9; i++) send_pixel(vecs[v].pix[i]);
      t9 = last_acc_edge;
      idle_in();
      wait_results(1, 20);
      check({vecs[v].name, "_count"}, 32'(got_q.size()), 32'd1);
      if (got_q.size() > 0) begin
        check(vecs[v].name, 32'(got_q[0]), 32'(vecs[v].exp));
        if (v == 0) check("latency_edges", 32'(got_edge[0] - t9), 32'd2);
      end
    end

    // Result sink busy across two windows.
    got_q.delete();
    u_res.busy = 1'b1;
    for (int i = 0; i < 9; i++) send_pixel(24'h010101);
    idle_in();
    step(4);
    check("bp_first_vld", 32'(u_res.vld), 32'd1);
    check("bp_first_data", 32'(u_res.data), 32'h010101);
    u_in.vld  = 1'b1;
    u_in.data = 24'h020202;
    step(8);
    check("bp_in_busy", 32'(u_in.busy), 32'd1);
    check("bp_held_data", 32'(u_res.data), 32'h010101);
    check("bp_no_xfer", 32'(got_q.size()), 32'd0);
    u_res.busy = 1'b0;
    for (int i = 0; i < 9; i++) send_pixel(24'h020202);
    idle_in();
    wait_results(2, 30);
    check("bp_count", 32'(got_q.size()), 32'd2);
    if (got_q.size() >= 2) begin
      check("bp_order0", 32'(got_q[0]), 32'h010101);
      check("bp_order1", 32'(got_q[1]), 32'h020202);
    end

    // Reset mid-window discards the partial sums.
    got_q.delete();
    for (int i = 0; i < 5; i++) send_pixel(24'hFFFFFF);
    idle_in();
    step(3);
    i_rst = 1'b1;
    step(1);
    i_rst = 1'b0;
    for (int i = 0; i < 9; i++) send_pixel(24'h090909);
    idle_in();
    wait_results(1, 20);
    check("rst_mid_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) check("rst_mid_data", 32'(got_q[0]), 32'h090909);

    // Random loopback stalls over three windows.
    got_q.delete();
    for (int i = 0; i < 27; i++) rpix[i] = 24'($urandom);
    fork
      begin
        for (int i = 0; i < 27; i++) begin
          send_pixel(rpix[i]);
          if ($urandom_range(0, 3) == 0) begin
            idle_in();
            step(1);
          end
        end
        idle_in();
      end
      begin
        repeat (400) begin
          r_stall = 1'($urandom_range(0, 1));
          step(1);
        end
        r_stall = 1'b0;
      end
    join
    wait_results(3, 50);
    check("rand_count", 32'(got_q.size()), 32'd3);
    for (int w = 0; w < 3; w++) begin
      sr = 0; sg = 0; sb = 0;
      for (int i = 0; i < 9; i++) begin
        sr += int'(rpix[w*9+i][7:0]);
        sg += int'(rpix[w*9+i][15:8]);
        sb += int'(rpix[w*9+i][23:16]);
      end
      if (got_q.size() > w)
        check($sformatf("rand_win%0d", w), 32'(got_q[w]),
              32'({8'(sb / 9), 8'(sg / 9), 8'(sr / 9)}));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
